// File: rtl/return_stack_pkg.sv
// Shared CPU control-path constants and types for the return-address stack.
package return_stack_pkg;

  localparam int RS_ADDR_W = 8;
  localparam int RS_DEPTH  = 8;
  localparam int RS_SP_W   = $clog2(RS_DEPTH);

  // Operation for one enabled edge, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } rs_op_e;

endpackage

// File: rtl/return_stack_mem.sv
// DEPTH x ADDR_W register array: one synchronous write port, one asynchronous read port.
module return_stack_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int SP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SP_W-1:0]   waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [SP_W-1:0]   raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack for the fetch-stage PC mux: CALL pushes, RET pops, sticky error flags.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int ADDR_W = RS_ADDR_W,
  parameter int DEPTH  = RS_DEPTH,
  localparam int SP_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] top_addr,
  output logic [SP_W-1:0]   sp,
  output logic [SP_W:0]     count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [SP_W:0] ONE     = (SP_W + 1)'(1);
  localparam logic [SP_W:0] DEPTH_C = (SP_W + 1)'(DEPTH);

  logic [SP_W:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [SP_W:0]     cnt_m1;
  logic [SP_W-1:0]   sp_w;
  logic              empty_w, full_w;
  logic              we;
  logic [SP_W-1:0]   waddr;
  logic [ADDR_W-1:0] rdata;
  rs_op_e            op;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);
  assign cnt_m1  = count_q - ONE;
  assign sp_w    = empty_w ? '0 : cnt_m1[SP_W-1:0];
  assign op      = rs_op_e'({en & push, en & pop});

  // Pop is applied before push, so push+pop on a non-empty stack overwrites the top.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    we      = 1'b0;
    waddr   = sp_w;
    case (op)
      OP_POP: begin
        if (empty_w) unf_d = 1'b1;
        else         count_d = cnt_m1;
      end
      OP_PUSH: begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = count_q[SP_W-1:0];
          count_d = count_q + ONE;
        end
      end
      OP_REPL: begin
        we = 1'b1;
        if (empty_w) begin
          unf_d   = 1'b1;
          waddr   = '0;
          count_d = ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  return_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SP_W   (SP_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (sp_w),
    .rdata (rdata)
  );

  // Stale entries stay in the array after a pop, so mask the read when empty.
  assign top_addr  = empty_w ? '0 : rdata;
  assign sp        = sp_w;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed table-driven bench for return_stack plus hand sequences for reset and full-replace cases.
module tb_return_stack;
  import return_stack_pkg::*;

  localparam int AW = RS_ADDR_W;
  localparam int SW = RS_SP_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, push, pop, clr_err;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic [SW-1:0] sp;
  logic [SW:0]   count;
  logic          empty, full, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  return_stack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .clr_err   (clr_err),
    .top_addr  (top_addr),
    .sp        (sp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, push, pop, clr;
    logic [AW-1:0] addr;
    logic [AW-1:0] top;
    logic [SW-1:0] sp;
    logic [SW:0]   cnt;
    logic          emp, full, ov, un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(input logic e, input logic pu, input logic po, input logic c,
                             input logic [AW-1:0] a, input logic [AW-1:0] t,
                             input logic [SW-1:0] s, input logic [SW:0] n,
                             input logic em, input logic fu, input logic o, input logic u);
    vec_t v;
    v.en = e; v.push = pu; v.pop = po; v.clr = c; v.addr = a;
    v.top = t; v.sp = s; v.cnt = n; v.emp = em; v.full = fu; v.ov = o; v.un = u;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [AW-1:0] t, input logic [SW-1:0] s,
                           input logic [SW:0] n, input logic em, input logic fu,
                           input logic o, input logic u);
    chk("top_addr", idx, 32'(top_addr), 32'(t));
    chk("sp", idx, 32'(sp), 32'(s));
    chk("count", idx, 32'(count), 32'(n));
    chk("empty", idx, 32'(empty), 32'(em));
    chk("full", idx, 32'(full), 32'(fu));
    chk("overflow", idx, 32'(overflow), 32'(o));
    chk("underflow", idx, 32'(underflow), 32'(u));
  endtask

  task automatic step(input logic e, input logic pu, input logic po, input logic c, input logic [AW-1:0] a);
    @(negedge clk);
    en = e; push = pu; pop = po; clr_err = c; push_addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_addr = '0;

    // Stimulus table: en push pop clr addr | top sp cnt empty full ov un
    vecs.push_back(V(1,1,0,0,8'h10, 8'h10,0,1,0,0,0,0));
    vecs.push_back(V(1,1,0,0,8'h20, 8'h20,1,2,0,0,0,0));
    vecs.push_back(V(1,1,0,0,8'h30, 8'h30,2,3,0,0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h20,1,2,0,0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h10,0,1,0,0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h00,0,0,1,0,0,0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(V(1,1,0,0,AW'(k), AW'(k),SW'(k-1),(SW+1)'(k),0,(k == 8),0,0));
    vecs.push_back(V(1,1,0,0,8'h99, 8'h08,7,8,0,1,1,0));
    vecs.push_back(V(1,0,0,1,8'h00, 8'h08,7,8,0,1,0,0));
    for (int k = 7; k >= 0; k--)
      vecs.push_back(V(1,0,1,0,8'h00, AW'(k),SW'((k > 0) ? k-1 : 0),(SW+1)'(k),(k == 0),0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h00,0,0,1,0,0,1));
    vecs.push_back(V(1,1,1,0,8'h55, 8'h55,0,1,0,0,0,1));
    vecs.push_back(V(1,0,0,1,8'h00, 8'h55,0,1,0,0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h00,0,0,1,0,0,0));
    vecs.push_back(V(1,1,0,0,8'h11, 8'h11,0,1,0,0,0,0));
    vecs.push_back(V(1,1,0,0,8'h22, 8'h22,1,2,0,0,0,0));
    vecs.push_back(V(1,1,1,0,8'h77, 8'h77,1,2,0,0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h11,0,1,0,0,0,0));
    vecs.push_back(V(0,1,0,0,8'h33, 8'h11,0,1,0,0,0,0));
    vecs.push_back(V(0,0,1,0,8'h00, 8'h11,0,1,0,0,0,0));
    vecs.push_back(V(1,0,1,0,8'h00, 8'h00,0,0,1,0,0,0));
    vecs.push_back(V(1,0,1,1,8'h00, 8'h00,0,0,1,0,0,1));
    vecs.push_back(V(0,0,1,0,8'h00, 8'h00,0,0,1,0,0,1));
    vecs.push_back(V(0,0,0,1,8'h00, 8'h00,0,0,1,0,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 8'h00, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr);
      check_all(i, vecs[i].top, vecs[i].sp, vecs[i].cnt, vecs[i].emp, vecs[i].full,
                vecs[i].ov, vecs[i].un);
    end

    // Full stack: push+pop replaces top without overflow, then a plain push overflows
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, AW'(8'h80 + k));
    check_all(100, 8'h87, 7, 8, 0, 1, 0, 0);
    step(1, 1, 1, 0, 8'hAA);
    check_all(101, 8'hAA, 7, 8, 0, 1, 0, 0);
    step(1, 1, 0, 0, 8'hBB);
    check_all(102, 8'hAA, 7, 8, 0, 1, 1, 0);
    step(1, 0, 1, 0, 8'h00);
    check_all(103, 8'h86, 6, 7, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle, then first push lands in entry 0
    step(1, 0, 0, 1, 8'h00);
    step(1, 1, 0, 0, 8'hC1);
    check_all(104, 8'hC1, 7, 8, 0, 1, 0, 0);
    en = 1'b0; push = 1'b0; clr_err = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all(105, 8'h00, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 8'h42);
    check_all(106, 8'h42, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 8'h43);
    check_all(107, 8'h43, 1, 2, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
